// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchronised input, single-point mid-bit sampling,
// one-cycle data/framing/parity strobes. Parity bit support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_Serial_Data,
  output logic                 o_DV,
  output logic [DATA_BITS-1:0] o_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_C    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_rx_param: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 ferr, ferr_n;
  logic                 par_flag;
  logic                 meta, rx;

  // Only rx (second flop) feeds the FSM; both flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx   <= 1'b1;
    end else begin
      meta <= i_Serial_Data;
      rx   <= meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr, perr_n;
  assign par_flag = perr;
  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else     perr <= perr_n;
  end
`else
  assign par_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
      ferr   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      data_q <= data_n;
      ferr   <= ferr_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    data_n       = data_q;
    ferr_n       = ferr;
`ifdef UART_RX_PARITY_EN
    perr_n       = perr;
`endif
    o_DV         = 1'b0;
    o_Frame_Err  = 1'b0;
    o_Parity_Err = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n = 1'b0;
`endif
        if (!rx) state_n = START;
      end
      START: begin
        if (cnt == HALF_C) begin
          cnt_n   = '0;
          state_n = rx ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST_C) begin
          cnt_n = '0;
          for (int i = 0; i < DATA_BITS; i++)
            if (idx == IW'(i)) data_n[i] = rx;
          if (idx == LAST_BIT) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST_C) begin
          cnt_n   = '0;
          perr_n  = ((^data_q) ^ rx) != (PARITY_ODD != 0);
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST_C) begin
          cnt_n = '0;
          if (!rx) ferr_n = 1'b1;
          if (idx == LAST_STOP) begin
            idx_n   = '0;
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        o_DV         = ~ferr & ~par_flag;
        o_Frame_Err  = ferr;
        o_Parity_Err = par_flag;
        // A low stop bit may be a held-low line; wait for it to return high before re-arming.
        state_n      = ferr ? BREAK : IDLE;
      end
      BREAK: begin
        if (rx) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_Byte = data_q;
  assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8-bit/1-stop and 5-bit/2-stop) checked every cycle
// against a sample-time schedule model of the receiver, plus directed per-frame strobe counts.
module tb_uart_rx_param;
  localparam int C0 = 87, DB0 = 8, SB0 = 1, PO0 = 0;
  localparam int C1 = 10, DB1 = 5, SB1 = 2, PO1 = 1;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int MAXC = 60000;

  logic clk, rst, line0, line1;
  logic dv0, fe0, pe0, busy0, dv1, fe1, pe1, busy1;
  logic [7:0] byte0;
  logic [4:0] byte1;

  uart_rx_param #(.CLKS_PER_BIT(C0), .DATA_BITS(DB0), .STOP_BITS(SB0), .PARITY_ODD(PO0)) u0 (
    .clk(clk), .rst(rst), .i_Serial_Data(line0), .o_DV(dv0), .o_Byte(byte0),
    .o_Frame_Err(fe0), .o_Parity_Err(pe0), .o_Busy(busy0));
  uart_rx_param #(.CLKS_PER_BIT(C1), .DATA_BITS(DB1), .STOP_BITS(SB1), .PARITY_ODD(PO1)) u1 (
    .clk(clk), .rst(rst), .i_Serial_Data(line1), .o_DV(dv1), .o_Byte(byte1),
    .o_Frame_Err(fe1), .o_Parity_Err(pe1), .o_Busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic pin0 [0:MAXC];
  logic pin1 [0:MAXC];
  logic rstl [0:MAXC];

  // Model: the receiver as a schedule of absolute sample cycles measured from T0.
  int         m_t0 [2], m_free [2], m_scyc [2];
  bit         m_brk [2], m_ferr [2], m_perr [2], m_sdv [2], m_sfe [2], m_spe [2];
  logic [8:0] m_byte [2], m_sbyte [2];
  int dv_cnt [2], fe_cnt [2], pe_cnt [2], m_dvc [2];
  int s_dv [2], s_fe [2], s_pe [2], s_mdv [2];
  logic [8:0] last_byte [2];
  logic [8:0] hist1 [$];

  function automatic int cfg_c(input int u);  return u == 0 ? C0 : C1;   endfunction
  function automatic int cfg_db(input int u); return u == 0 ? DB0 : DB1; endfunction
  function automatic int cfg_sb(input int u); return u == 0 ? SB0 : SB1; endfunction
  function automatic int cfg_po(input int u); return u == 0 ? PO0 : PO1; endfunction

  task automatic model_reset(input int u);
    m_t0[u] = -1; m_free[u] = 0; m_scyc[u] = -1; m_brk[u] = 0;
    m_ferr[u] = 0; m_perr[u] = 0; m_byte[u] = '0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
  end

  // rx seen by the FSM in cycle c: pin two cycles earlier, forced high around reset.
  function automatic logic rxm(input int u, input int c);
    if (c < 3) return 1'b1;
    if (rstl[c-1] || rstl[c-2]) return 1'b1;
    return (u == 0) ? pin0[c-2] : pin1[c-2];
  endfunction

  task automatic model_step(input int u, input int c, input logic rxv);
    int cc, half, d, k, ntot;
    cc = cfg_c(u); half = (cc - 1) / 2; ntot = cfg_db(u) + P + cfg_sb(u);
    if (c < m_free[u]) return;
    if (m_brk[u]) begin
      if (rxv) begin m_brk[u] = 0; m_free[u] = c + 1; end
      return;
    end
    if (m_t0[u] < 0) begin
      if (!rxv) begin m_t0[u] = c; m_ferr[u] = 0; m_perr[u] = 0; end
      return;
    end
    d = c - m_t0[u] - 1 - half;
    if (d == 0) begin
      if (rxv) begin m_t0[u] = -1; m_free[u] = c + 1; end
      return;
    end
    if (d < 0 || (d % cc) != 0) return;
    k = d / cc;
    if (k <= cfg_db(u)) m_byte[u][k-1] = rxv;
    else if (k <= cfg_db(u) + P) m_perr[u] = ((^m_byte[u]) ^ rxv ^ cfg_po(u)[0]) != 1'b0;
    else if (!rxv) m_ferr[u] = 1;
    if (k == ntot) begin
      m_scyc[u] = c + 1; m_sdv[u] = !m_ferr[u] && !m_perr[u];
      m_sfe[u] = m_ferr[u]; m_spe[u] = m_perr[u]; m_sbyte[u] = m_byte[u];
      m_t0[u] = -1; m_free[u] = c + 2; m_brk[u] = m_ferr[u];
    end
  endtask

  task automatic compare(input int u, input int c);
    logic gdv, gfe, gpe, gbusy, edv, efe, epe, ebusy;
    logic [8:0] gbyte;
    gdv   = (u == 0) ? dv0 : dv1;     gfe = (u == 0) ? fe0 : fe1;
    gpe   = (u == 0) ? pe0 : pe1;     gbusy = (u == 0) ? busy0 : busy1;
    gbyte = (u == 0) ? {1'b0, byte0} : {4'b0, byte1};
    edv   = (m_scyc[u] == c) && m_sdv[u];
    efe   = (m_scyc[u] == c) && m_sfe[u];
    epe   = (m_scyc[u] == c) && m_spe[u];
    ebusy = !(m_t0[u] < 0 && !m_brk[u] && c >= m_free[u]);
    tests++;
    if (gdv !== edv || gfe !== efe || gpe !== epe || gbusy !== ebusy ||
        (edv && gbyte !== m_sbyte[u])) begin
      fails++;
      $display("FAIL cycle u%0d c%0d: got dv/fe/pe/busy=%b%b%b%b byte=%h, need %b%b%b%b byte=%h",
               u, c, gdv, gfe, gpe, gbusy, gbyte, edv, efe, epe, ebusy, m_sbyte[u]);
    end
    if (edv) m_dvc[u]++;
    if (gdv === 1'b1) begin
      dv_cnt[u]++; last_byte[u] = gbyte;
      if (u == 1) hist1.push_back(gbyte);
    end
    if (gfe === 1'b1) fe_cnt[u]++;
    if (gpe === 1'b1) pe_cnt[u]++;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cyc <= MAXC) begin
      pin0[cyc] = line0; pin1[cyc] = line1; rstl[cyc] = rst;
      for (int u = 0; u < 2; u++) begin
        if (cyc >= 2 && rstl[cyc-1]) model_reset(u);
        compare(u, cyc);
        model_step(u, cyc, rxm(u, cyc));
      end
    end
  end

  task automatic expect_i(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  task automatic mark();
    for (int u = 0; u < 2; u++) begin
      s_dv[u] = dv_cnt[u]; s_fe[u] = fe_cnt[u]; s_pe[u] = pe_cnt[u]; s_mdv[u] = m_dvc[u];
    end
  endtask

  task automatic phase_check(input string nm, input int u, input int ndv, input int nfe, input int npe);
    expect_i({nm, " dv count"}, dv_cnt[u] - s_dv[u], ndv);
    expect_i({nm, " frame err count"}, fe_cnt[u] - s_fe[u], nfe);
    expect_i({nm, " parity err count"}, pe_cnt[u] - s_pe[u], npe);
    expect_i({nm, " model dv count"}, m_dvc[u] - s_mdv[u], ndv);
    expect_i({nm, " busy after"}, int'(u == 0 ? busy0 : busy1), 0);
    mark();
  endtask

  task automatic drive(input int u, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (u == 0) line0 = v; else line1 = v;
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int u, input logic [8:0] d, input bit bad_par, input bit stop_low);
    int c;
    c = cfg_c(u);
    drive(u, 1'b0, c);
    for (int i = 0; i < cfg_db(u); i++) drive(u, d[i], c);
    if (P == 1) drive(u, (^d) ^ cfg_po(u)[0] ^ bad_par, c);
    for (int s = 0; s < cfg_sb(u); s++) drive(u, !stop_low, c);
  endtask

  initial begin
    rst = 1'b1; line0 = 1'b1; line1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_i("reset byte0", int'(byte0), 0);
    expect_i("reset byte1", int'(byte1), 0);
    expect_i("reset strobes0", int'({dv0, fe0, pe0, busy0}), 0);
    expect_i("reset strobes1", int'({dv1, fe1, pe1, busy1}), 0);
    rst = 1'b0;
    drive(0, 1'b1, 5);
    mark();

    send(0, 9'h0A5, 0, 0); drive(0, 1'b1, 2 * C0);
    phase_check("8N1 A5", 0, 1, 0, 0);
    expect_i("8N1 A5 byte", int'(last_byte[0]), 'hA5);

    drive(0, 1'b0, 30); drive(0, 1'b1, 3 * C0);
    phase_check("start glitch", 0, 0, 0, 0);
    send(0, 9'h03C, 0, 0); drive(0, 1'b1, 2 * C0);
    phase_check("after glitch 3C", 0, 1, 0, 0);
    expect_i("after glitch byte", int'(last_byte[0]), 'h3C);

    send(0, 9'h055, 0, 1); drive(0, 1'b0, 500); drive(0, 1'b1, 3 * C0);
    phase_check("framing 55", 0, 0, 1, 0);
    send(0, 9'h00F, 0, 0); drive(0, 1'b1, 2 * C0);
    phase_check("after break 0F", 0, 1, 0, 0);
    expect_i("after break byte", int'(last_byte[0]), 'h0F);

`ifdef UART_RX_PARITY_EN
    send(0, 9'h081, 1, 0); drive(0, 1'b1, 2 * C0);
    phase_check("bad even parity 81", 0, 0, 0, 1);
    send(0, 9'h081, 0, 1); drive(0, 1'b0, 100); drive(0, 1'b1, 3 * C0);
    phase_check("parity+framing 81", 0, 0, 1, 1);
    send(1, 9'h00B, 1, 0); drive(1, 1'b1, 3 * C1);
    phase_check("bad odd parity 0B", 1, 0, 0, 1);
`endif
    send(0, 9'h081, 0, 0); drive(0, 1'b1, 2 * C0);
    phase_check("good 81", 0, 1, 0, 0);
    expect_i("good 81 byte", int'(last_byte[0]), 'h81);

    hist1.delete();
    send(1, 9'h01F, 0, 0); send(1, 9'h00A, 0, 0); drive(1, 1'b1, 3 * C1);
    phase_check("5N2 back-to-back", 1, 2, 0, 0);
    expect_i("b2b count", hist1.size(), 2);
    if (hist1.size() == 2) begin
      expect_i("b2b first byte", int'(hist1[0]), 'h1F);
      expect_i("b2b second byte", int'(hist1[1]), 'h0A);
    end

    drive(0, 1'b0, C0);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, C0);
    drive(0, 1'b1, C0 / 2);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    drive(0, 1'b1, 12 * C0);
    phase_check("reset mid-frame FF", 0, 0, 0, 0);
    expect_i("reset mid-frame u1 dv", dv_cnt[1] - s_dv[1], 0);
    send(0, 9'h042, 0, 0); drive(0, 1'b1, 2 * C0);
    phase_check("after reset 42", 0, 1, 0, 0);
    expect_i("after reset byte", int'(last_byte[0]), 'h42);

    if (cyc > MAXC) begin
      fails++;
      $display("FAIL cycle budget: got %0d cycles, need at most %0d", cyc, MAXC);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation serial-input block for the communication subsystem. It samples an asynchronous serial line at mid-bit and delivers a configurable-width data word with a one-cycle valid strobe. Data width, stop-bit count and bit period are configurable; it also reports framing and parity errors. It sits between the board RX pin and any byte-consuming logic, such as a FIFO or command decoder.

## Interface
Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_Serial_Data  input  1  asynchronous serial line; idles high.
- o_DV  output  1  one-cycle strobe: o_Byte holds a good frame.
- o_Byte  output  DATA_BITS  received word, LSB first on the line.
- o_Frame_Err  output  1  one-cycle strobe: a stop bit was sampled low.
- o_Parity_Err  output  1  one-cycle strobe: parity mismatch.
- o_Busy  output  1  high in every state except IDLE.

## Operation
- Input path: 2-flop synchronizer. Both flops reset to 1. The FSM uses only the second flop output, called rx.
- Counter width: $clog2(CLKS_PER_BIT). HALF = (CLKS_PER_BIT-1)/2, integer division.
- FSM states: IDLE, START, DATA, PARITY (only if the macro is defined), STOP, DONE, BREAK.
- IDLE: counter = 0, bit index = 0.
  - rx == 0 → START.
- START: count up to HALF, then sample rx.
  - rx == 0 → DATA, counter cleared.
  - rx == 1 → IDLE (glitch rejected, no strobe).
- DATA: count to CLKS_PER_BIT-1, then sample rx into o_Byte[index] and clear the counter.
  - After index DATA_BITS-1 → PARITY if the macro is defined, else STOP.
- PARITY: one bit period, then sample rx. Parity check:
  - Even (PARITY_ODD=0): XOR of the data bits and the parity bit must be 0.
  - Odd (PARITY_ODD=1): that XOR must be 1.
  - A failed check sets an internal error flag.
- STOP: one bit period per stop bit, sample rx each time. Any stop sample of 0 sets the framing flag.
  - After the last stop sample → DONE.
- DONE (one cycle):
  - No error flags: o_DV = 1.
  - Framing flag set: o_Frame_Err = 1.
  - Parity flag set: o_Parity_Err = 1.
  - Both flags set: both error strobes pulse; o_DV stays 0.
  - Next state: BREAK if the framing flag is set, else IDLE.
- BREAK: stay until rx == 1, then → IDLE. A held-low line produces exactly one o_Frame_Err.
- o_Byte is updated bit-by-bit as bits arrive. It holds its last value between frames and is valid only when o_DV is high.
- Unused or illegal state encodings → IDLE on the next cycle.

## Timing
- Reset values:
  - o_DV = 0, o_Frame_Err = 0, o_Parity_Err = 0, o_Busy = 0.
  - o_Byte = 0, state = IDLE, counter = 0, index = 0.
  - Both synchronizer flops = 1.
- Reset mid-frame: the frame is abandoned with no strobe. The receiver re-arms on the next low rx after reset deasserts.
- Synchronizer latency: 2 cycles from pin to rx.
- Sample times: T0 is the first cycle rx == 0 while in IDLE. With P = 1 if the macro is defined, else 0:
  - Start sample at T0+1+HALF.
  - Sample k (k = 1..DATA_BITS+P+STOP_BITS) at T0+1+HALF+k*CLKS_PER_BIT.
- Strobe timing: o_DV or the error strobes are high for exactly one cycle, one cycle after the final stop sample. They are never high together with each other, except both error strobes in the two-error case.
- Back-to-back frames: the FSM is in IDLE by mid-stop-bit + 2 cycles, so a start bit immediately after the stop bit is captured.
- Oversampling: samples are single-point at mid-bit; there is no majority vote.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state exists, one parity bit is expected after the data bits, and o_Parity_Err is active.
  - Undefined: no parity bit is expected, the PARITY state is not synthesised, and o_Parity_Err is tied to 0.

## Test plan
- 8N1 frame, CLKS_PER_BIT=87, send 0xA5 → o_DV pulses once with o_Byte=0xA5; no error strobes; o_Busy low afterwards.
- Start glitch: 30 cycles low, then high → no strobe; FSM returns to IDLE; a following 0x3C frame is received correctly.
- Framing error: 0x55 with the stop bit driven low, line held low 500 cycles → exactly one o_Frame_Err pulse, no o_DV. The next 0x0F frame after the line returns high gives o_DV with o_Byte=0x0F.
- Macro defined, PARITY_ODD=0: 0x81 with parity bit 1 → o_Parity_Err pulses, o_DV stays 0. The same frame with parity bit 0 → o_DV with o_Byte=0x81.
- DATA_BITS=5, STOP_BITS=2: frames 0x1F and 0x0A sent back-to-back with no idle gap → two o_DV pulses, o_Byte=0x1F then 0x0A.
- rst asserted during data bit 4 of frame 0xFF for 1 cycle → no strobe. The next frame 0x42 is received correctly.
